// File: rtl/mps_pkg.sv
// Shared types for multi_pulse_stim.
// Defining MPS_DUTY_EN replaces half_per with separate t_hi/t_lo segment lengths.
package mps_pkg;

   localparam int MPS_CNTW = 16;
   localparam int MPS_NPW  = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } mps_state_e;

   // The part of the configuration that must survive past the start edge.
   typedef struct packed {
`ifdef MPS_DUTY_EN
      logic [MPS_CNTW-1:0] t_hi;
      logic [MPS_CNTW-1:0] t_lo;
`else
      logic [MPS_CNTW-1:0] half_per;
`endif
      logic [MPS_NPW-1:0]  npulse;
   } mps_run_cfg_t;

   typedef struct packed {
      logic [MPS_CNTW-1:0] dly;
      mps_run_cfg_t        run;
   } mps_cfg_t;

endpackage

// File: rtl/multi_pulse_stim_if.sv
// Control/status bundle for multi_pulse_stim; master drives config and masks, slave is the generator.
// Handshake: en is a level; a run starts on its rising edge while idle, busy/done report progress.
// Defining MPS_DUTY_EN swaps half_per for t_hi/t_lo.
interface multi_pulse_stim_if #(
   parameter int NCH  = 2,
   parameter int CNTW = 16,
   parameter int NPW  = 20
);
   import mps_pkg::*;

   logic            en;
   logic [CNTW-1:0] dly;
`ifdef MPS_DUTY_EN
   logic [CNTW-1:0] t_hi;
   logic [CNTW-1:0] t_lo;
`else
   logic [CNTW-1:0] half_per;
`endif
   logic [NPW-1:0]  npulse;
   logic [NCH-1:0]  ch_en;
   logic [NCH-1:0]  ch_inv;
   logic [NCH-1:0]  pulse;
   logic            busy;
   logic            done;
   logic [NPW-1:0]  pcnt;
   mps_state_e      state;

   modport master (
      output en, dly,
`ifdef MPS_DUTY_EN
      output t_hi, t_lo,
`else
      output half_per,
`endif
      output npulse, ch_en, ch_inv,
      input  pulse, busy, done, pcnt, state
   );

   modport slave (
      input  en, dly,
`ifdef MPS_DUTY_EN
      input  t_hi, t_lo,
`else
      input  half_per,
`endif
      input  npulse, ch_en, ch_inv,
      output pulse, busy, done, pcnt, state
   );

endinterface

// File: rtl/mps_timer.sv
// Loadable down-counter; expire is high for the single cycle in which the count sits at 1.
module mps_timer #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            load,
   input  logic [CNTW-1:0] val,
   output logic            expire
);

   logic [CNTW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (val == '0) ? CNTW'(1) : val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == CNTW'(1));

endmodule

// File: rtl/multi_pulse_stim.sv
// Multi-channel square-wave stimulus generator: start delay, programmable period, finite pulse count.
// Defining MPS_DUTY_EN selects asymmetric high/low segment lengths (t_hi/t_lo).
module multi_pulse_stim
   import mps_pkg::*;
#(
   parameter int   NCH      = 2,
   parameter int   CNTW     = MPS_CNTW,
   parameter int   NPW      = MPS_NPW,
   parameter logic INIT_LVL = 1'b1
) (
   input logic               clk,
   input logic               rstn,
   multi_pulse_stim_if.slave bus
);

   mps_state_e      state;
   mps_cfg_t        cfg_in;
   mps_run_cfg_t    cfg_q;
   logic            base;
   logic            en_q;
   logic            busy_r;
   logic            done_r;
   logic [NPW-1:0]  pcnt_r;
   logic            start;
   logic            expire;
   logic            tmr_load;
   logic [CNTW-1:0] tmr_val;
   logic [CNTW-1:0] len_start;
   logic [CNTW-1:0] len_cur;
   logic [CNTW-1:0] len_flip;

   always_comb begin
      cfg_in              = '0;
      cfg_in.dly          = MPS_CNTW'(bus.dly);
`ifdef MPS_DUTY_EN
      cfg_in.run.t_hi     = MPS_CNTW'(bus.t_hi);
      cfg_in.run.t_lo     = MPS_CNTW'(bus.t_lo);
`else
      cfg_in.run.half_per = MPS_CNTW'(bus.half_per);
`endif
      cfg_in.run.npulse   = MPS_NPW'(bus.npulse);
   end

   // Segment lengths: at start (live inputs), for the current level, and for the level after a toggle.
`ifdef MPS_DUTY_EN
   assign len_start = INIT_LVL ? CNTW'(cfg_in.run.t_hi) : CNTW'(cfg_in.run.t_lo);
   assign len_cur   = base ? CNTW'(cfg_q.t_hi) : CNTW'(cfg_q.t_lo);
   assign len_flip  = base ? CNTW'(cfg_q.t_lo) : CNTW'(cfg_q.t_hi);
`else
   assign len_start = CNTW'(cfg_in.run.half_per);
   assign len_cur   = CNTW'(cfg_q.half_per);
   assign len_flip  = CNTW'(cfg_q.half_per);
`endif

   assign start = (state == IDLE) && bus.en && !en_q;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = len_cur;
      case (state)
         IDLE: begin
            if (start) begin
               tmr_load = 1'b1;
               tmr_val  = (cfg_in.dly != '0) ? CNTW'(cfg_in.dly) : len_start;
            end
         end
         DELAY: begin
            if (expire) begin
               tmr_load = 1'b1;
               tmr_val  = len_cur;
            end
         end
         RUN: begin
            if (expire) begin
               tmr_load = 1'b1;
               tmr_val  = len_flip;
            end
         end
         default: ;
      endcase
   end

   mps_timer #(.CNTW(CNTW)) u_timer (
      .clk    (clk),
      .rstn   (rstn),
      .load   (tmr_load),
      .val    (tmr_val),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         base   <= INIT_LVL;
         pcnt_r <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         en_q   <= 1'b0;
         cfg_q  <= '0;
      end else begin
         en_q <= bus.en;
         if ((state == DELAY || state == RUN) && !bus.en) begin
            state  <= IDLE;
            base   <= INIT_LVL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     cfg_q  <= cfg_in.run;
                     pcnt_r <= '0;
                     busy_r <= 1'b1;
                     state  <= (cfg_in.dly == '0) ? RUN : DELAY;
                  end
               end
               DELAY: begin
                  if (expire) state <= RUN;
               end
               RUN: begin
                  // Completion is seen the cycle after the last period closes, with base already at rest.
                  if (cfg_q.npulse != '0 && pcnt_r == NPW'(cfg_q.npulse)) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                  end else if (expire) begin
                     base <= ~base;
                     if (base != INIT_LVL && pcnt_r != '1) pcnt_r <= pcnt_r + 1'b1;
                  end
               end
               DONE: begin
                  if (!bus.en) begin
                     state  <= IDLE;
                     done_r <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.pulse = ((bus.ch_en & {NCH{base}}) | (~bus.ch_en & {NCH{INIT_LVL}})) ^ bus.ch_inv;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.pcnt  = pcnt_r;
   assign bus.state = state;

endmodule

// File: tb/tb_multi_pulse_stim.sv
// Randomised bench for multi_pulse_stim against a closed-form waveform model of each run.
module tb_multi_pulse_stim;

   localparam int   NCH  = 2;
   localparam int   CNTW = 16;
   localparam int   NPW  = 20;
   localparam logic INIT = 1'b1;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   always #5 clk = ~clk;

   multi_pulse_stim_if #(.NCH(NCH), .CNTW(CNTW), .NPW(NPW)) bus ();

   multi_pulse_stim #(
      .NCH      (NCH),
      .CNTW     (CNTW),
      .NPW      (NPW),
      .INIT_LVL (INIT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_vectors     = 0;
   int n_miscompares = 0;

   // Model of the current run: delay, first/second segment lengths, pulse count.
   int m_d;
   int m_l0;
   int m_l1;
   int m_n;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_model(input int d, input int a, input int b, input int n);
      int hi;
      int lo;
      hi = (a == 0) ? 1 : a;
`ifdef MPS_DUTY_EN
      lo = (b == 0) ? 1 : b;
`else
      lo = (b < 0) ? 1 : hi;
`endif
      m_d  = d;
      m_l0 = INIT ? hi : lo;
      m_l1 = INIT ? lo : hi;
      m_n  = n;
   endtask

   // Waveform k cycles after the start edge, assuming en stays high.
   function automatic void core(input int k, output logic b, output logic bsy, output logic dn,
                                output int pc);
      int t;
      int p;
      p = m_l0 + m_l1;
      if (k < m_d) begin
         b = INIT; bsy = 1'b1; dn = 1'b0; pc = 0;
      end else begin
         t = k - m_d;
         if (m_n != 0 && t > m_n * p) begin
            b = INIT; bsy = 1'b0; dn = 1'b1; pc = m_n;
         end else begin
            b   = ((t % p) < m_l0) ? INIT : ~INIT;
            bsy = 1'b1;
            dn  = 1'b0;
            pc  = t / p;
         end
      end
   endfunction

   function automatic void model(input int k, input int drop_k, output logic b, output logic bsy,
                                 output logic dn, output int pc);
      logic b0;
      logic s0;
      logic d0;
      int   p0;
      if (drop_k >= 0 && k >= drop_k) begin
         core(drop_k - 1, b0, s0, d0, p0);
         b = INIT; bsy = 1'b0; dn = 1'b0; pc = p0;
      end else begin
         core(k, b, bsy, dn, pc);
      end
   endfunction

   task automatic drive_cfg(input int d, input int a, input int b, input int n);
      bus.dly = CNTW'(d);
`ifdef MPS_DUTY_EN
      bus.t_hi = CNTW'(a);
      bus.t_lo = CNTW'(b);
`else
      bus.half_per = CNTW'(a + (b - b));
`endif
      bus.npulse = NPW'(n);
   endtask

   task automatic compare_state(input int k, input int drop_k);
      logic           b;
      logic           bsy;
      logic           dn;
      int             pc;
      logic [NCH-1:0] ep;
      model(k, drop_k, b, bsy, dn, pc);
      for (int i = 0; i < NCH; i++)
         ep[i] = bus.ch_en[i] ? (b ^ bus.ch_inv[i]) : (INIT ^ bus.ch_inv[i]);
      check("pulse", 32'(bus.pulse), 32'(ep));
      check("busy",  32'(bus.busy),  32'(bsy));
      check("done",  32'(bus.done),  32'(dn));
      check("pcnt",  32'(bus.pcnt),  32'(pc));
   endtask

   task automatic check_reset_vals();
      logic [NCH-1:0] ep;
      for (int i = 0; i < NCH; i++) ep[i] = INIT ^ bus.ch_inv[i];
      check("rst_pulse", 32'(bus.pulse), 32'(ep));
      check("rst_busy",  32'(bus.busy),  32'd0);
      check("rst_done",  32'(bus.done),  32'd0);
      check("rst_pcnt",  32'(bus.pcnt),  32'd0);
   endtask

   // One run: start on a rising en, compare every cycle, drop en at drop_k, optional reset at rst_k.
   task automatic run_case(input int d, input int a, input int b, input int n, input int drop_k,
                           input int rst_k, input bit rmask);
      int k;
      int len;
      int rk;
      @(negedge clk);
      drive_cfg(d, a, b, n);
      set_model(d, a, b, n);
      if (!rmask) begin
         bus.ch_en  = 2'b11;
         bus.ch_inv = 2'b10;
      end
      bus.en = 1'b1;
      @(posedge clk);
      k   = 0;
      rk  = rst_k;
      len = drop_k + 3;
      while (k < len) begin
         @(negedge clk);
         compare_state(k, drop_k);
         if (rmask) begin
            bus.ch_en  = NCH'($urandom_range(0, 3));
            bus.ch_inv = NCH'($urandom_range(0, 3));
         end
         drive_cfg($urandom_range(0, 9), 7, 7, $urandom_range(0, 5));
         if (k + 1 == drop_k) bus.en = 1'b0;
         if (k + 1 == rk) begin
            rstn = 1'b0;
            drive_cfg(d, a, b, n);
            @(posedge clk);
            @(negedge clk);
            check_reset_vals();
            rstn = 1'b1;
            rk   = -1;
            k    = 0;
            @(posedge clk);
            continue;
         end
         k++;
         @(posedge clk);
      end
      bus.en = 1'b0;
   endtask

   initial begin
      int d;
      int a;
      int b;
      int n;
      int p;
      int drop;

      bus.en     = 1'b0;
      bus.ch_en  = 2'b11;
      bus.ch_inv = 2'b10;
      drive_cfg(0, 1, 1, 0);
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      rstn = 1'b1;
      @(negedge clk);
      check_reset_vals();

      run_case(0, 4, 4, 3, 27, -1, 1'b0);
      run_case(10, 2, 2, 1, 17, -1, 1'b1);
      run_case(0, 1, 1, 0, 51, -1, 1'b1);
      run_case(3, 0, 0, 2, 9, -1, 1'b1);
      run_case(2, 3, 3, 2, 20, 7, 1'b1);
      run_case(0, 3, 5, 2, 19, -1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         d = $urandom_range(0, 6);
         a = $urandom_range(0, 5);
         b = $urandom_range(0, 5);
         n = $urandom_range(0, 3);
         set_model(d, a, b, n);
         p = m_l0 + m_l1;
         if (n != 0 && $urandom_range(0, 1) == 1) drop = d + n * p + $urandom_range(1, 4);
         else                                      drop = $urandom_range(1, d + 2 * p + 6);
         run_case(d, a, b, n, drop, -1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
